// File: rtl/aes_pkg.sv
// Shared AES definitions: block/word types, the key-schedule state
// encoding and the round-constant table.
// Optional build macro used by the key schedule: AES_KEY_ZEROIZE_EN.
package aes_pkg;

  // Round-key slots 0..10; slot 0 holds the cipher key itself.
  localparam int NUM_ROUND_KEYS = 11;
  localparam int ROUND_IDX_W    = 4;

  typedef logic [127:0]             block_t;
  typedef logic [31:0]              word_t;
  typedef logic [ROUND_IDX_W-1:0]   round_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } key_state_t;

  // Entry 0 is unused so the table is indexed directly by the
  // expansion counter (1..10).
  localparam logic [7:0] RCON [NUM_ROUND_KEYS] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Left byte rotate: [b0 b1 b2 b3] -> [b1 b2 b3 b0], b0 in the MSBs.
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Controller-facing bus of the AES-128 key schedule.
// Optional build macro: AES_KEY_ZEROIZE_EN adds the key_zeroize strobe.
//
// Handshake: key_load (and key_zeroize when built) are single-cycle
// strobes sampled at a rising clock edge; there is no ready back-pressure,
// a strobe is always accepted. key_busy and key_ready are levels:
// key_busy while expanding, key_ready once all 11 round keys are valid.
// round/round_key is a combinational lookup; round_key is only meaningful
// while key_ready is high. state mirrors the schedule FSM for observation.
interface aes_key_expand_if;

  logic                   key_load;
  aes_pkg::block_t        key_in;
  aes_pkg::round_idx_t    round;
  aes_pkg::block_t        round_key;
  logic                   key_busy;
  logic                   key_ready;
  aes_pkg::key_state_t    state;

`ifdef AES_KEY_ZEROIZE_EN
  logic                   key_zeroize;

  modport master (
    output key_load, key_in, round, key_zeroize,
    input  round_key, key_busy, key_ready, state
  );

  modport slave (
    input  key_load, key_in, round, key_zeroize,
    output round_key, key_busy, key_ready, state
  );
`else
  modport master (
    output key_load, key_in, round,
    input  round_key, key_busy, key_ready, state
  );

  modport slave (
    input  key_load, key_in, round,
    output round_key, key_busy, key_ready, state
  );
`endif

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Shared between the key schedule (SubWord) and the round datapath.
// No build macros affect this file (AES_KEY_ZEROIZE_EN is not used here).
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  // Row-major FIPS-197 table; entry 0x00 sits in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry d lives at bit offset (255-d)*8, i.e. {~d, 3'b000}.
  logic [10:0] bit_ofs;

  // Table lookup.
  always_comb begin
    bit_ofs = {~data_i, 3'b000};
    data_o  = SBOX_TABLE[bit_ofs +: 8];
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: captures a cipher key, expands one round key per
// cycle into an 11-entry register file, and serves any entry
// combinationally to the round controller.
// Optional build macro: AES_KEY_ZEROIZE_EN adds a key_zeroize strobe that
// wipes all round keys and returns to IDLE (it overrides key_load).
module aes_key_expand
  import aes_pkg::*;
#(
  // Fixed at 10 for AES-128; other values are not supported.
  parameter int NUM_ROUNDS = 10
) (
  input  logic              clk,
  input  logic              n_rst,
  aes_key_expand_if.slave   bus
);

  localparam round_idx_t LAST_ROUND = round_idx_t'(NUM_ROUNDS);

  block_t      slot_q [NUM_ROUND_KEYS];
  round_idx_t  counter_q;
  key_state_t  state_q;
  logic        busy_q;
  logic        ready_q;

  block_t      prev_key;
  word_t       rot_w;
  word_t       sub_w;
  word_t       t_w;
  logic [7:0]  rcon_sel;
  word_t       n0, n1, n2, n3;
  block_t      slot_d;

  // Previous round key and round constant for the slot being generated.
  // Outside EXPAND the counter is 0, so both fall back to zero.
  always_comb begin
    prev_key = '0;
    rcon_sel = 8'h00;
    if (counter_q != '0 && counter_q <= LAST_ROUND) begin
      prev_key = slot_q[counter_q - round_idx_t'(1)];
      rcon_sel = RCON[counter_q];
    end
  end

  // RotWord of the last word of the previous key feeds SubWord.
  assign rot_w = rot_word(prev_key[31:0]);

  for (genvar gi = 0; gi < 4; gi++) begin : g_subword
    aes_sbox u_sbox (
      .data_i (rot_w[8*gi +: 8]),
      .data_o (sub_w[8*gi +: 8])
    );
  end

  // Word chain of the expansion: each new word folds in the one before it.
  always_comb begin
    t_w    = sub_w ^ {rcon_sel, 24'h000000};
    n0     = prev_key[127:96] ^ t_w;
    n1     = prev_key[95:64]  ^ n0;
    n2     = prev_key[63:32]  ^ n1;
    n3     = prev_key[31:0]   ^ n2;
    slot_d = {n0, n1, n2, n3};
  end

  // Schedule FSM with register file and registered status outputs.
  // A new load restarts from slot 0 in any state; every slot 1..10 is
  // rewritten before key_ready rises, so no old-key material leaks through.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_ROUND_KEYS; i++) slot_q[i] <= '0;
      counter_q <= '0;
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end
`ifdef AES_KEY_ZEROIZE_EN
    else if (bus.key_zeroize) begin
      for (int i = 0; i < NUM_ROUND_KEYS; i++) slot_q[i] <= '0;
      counter_q <= '0;
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end
`endif
    else if (bus.key_load) begin
      slot_q[0] <= bus.key_in;
      counter_q <= round_idx_t'(1);
      state_q   <= EXPAND;
      busy_q    <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        EXPAND: begin
          slot_q[counter_q] <= slot_d;
          if (counter_q == LAST_ROUND) begin
            counter_q <= '0;
            state_q   <= READY;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
          end else begin
            counter_q <= counter_q + round_idx_t'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Zero-latency read port; indices beyond the last slot read as zero.
  assign bus.round_key = (bus.round <= LAST_ROUND) ? slot_q[bus.round] : '0;
  assign bus.key_busy  = busy_q;
  assign bus.key_ready = ready_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for the AES-128 key schedule. The reference derives the S-box from
// GF(2^8) inversion plus the affine map and runs the FIPS-197 word-wise
// key expansion; literal FIPS-197 vectors pin that reference.
// Optional build macro: AES_KEY_ZEROIZE_EN enables the zeroize scenario.
module tb_aes_key_expand;
  import aes_pkg::*;

  typedef logic [127:0] rk_arr_t [11];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk;
  logic n_rst;

  aes_key_expand_if bus ();

  aes_key_expand dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference arithmetic ----------------
  logic [7:0] sb_m [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] b);
    logic [7:0] inv = 8'h00;
    if (b != 8'h00) begin
      for (int x = 1; x < 256; x++)
        if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic rk_arr_t expand_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rk_arr_t     r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb_m[tmp[31:24]], sb_m[tmp[23:16]], sb_m[tmp[15:8]], sb_m[tmp[7:0]]}
              ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 11; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Timeline model: after a load sampled at edge N, slot k holds the new
  // round key from edge N+k on; earlier slots keep whatever they held.
  rk_arr_t     full_m;
  logic [127:0] mem_m [11];
  int          age_m;
  bit          active_m;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 11; i++) mem_m[i] <= '0;
      active_m <= 1'b0;
      age_m    <= 0;
    end
`ifdef AES_KEY_ZEROIZE_EN
    else if (bus.key_zeroize) begin
      for (int i = 0; i < 11; i++) mem_m[i] <= '0;
      active_m <= 1'b0;
      age_m    <= 0;
    end
`endif
    else if (bus.key_load) begin
      full_m   <= expand_key(bus.key_in);
      mem_m[0] <= bus.key_in;
      age_m    <= 0;
      active_m <= 1'b1;
    end else if (active_m && age_m < 10) begin
      mem_m[age_m+1] <= full_m[age_m+1];
      age_m          <= age_m + 1;
    end
  end

  // Every-cycle compare of status, state and the read port.
  always @(posedge clk) begin
    logic       exp_busy;
    logic       exp_ready;
    key_state_t exp_state;
    logic [127:0] exp_rk;
    #1;
    exp_busy  = active_m && (age_m < 10);
    exp_ready = active_m && (age_m == 10);
    exp_state = !active_m ? IDLE : (exp_busy ? EXPAND : READY);
    exp_rk    = (bus.round <= 4'd10) ? mem_m[bus.round] : 128'h0;
    check("cyc_busy", 128'(bus.key_busy), 128'(exp_busy));
    check("cyc_ready", 128'(bus.key_ready), 128'(exp_ready));
    check("cyc_state", 128'(bus.state), 128'(exp_state));
    check("cyc_round_key", bus.round_key, exp_rk);
  end

  // ---------------- driver tasks ----------------
  task automatic load_key(input logic [127:0] k);
    @(negedge clk);
    bus.key_in   = k;
    bus.key_load = 1'b1;
    @(negedge clk);
    bus.key_load = 1'b0;
  endtask

  // Counts edges after the load edge until key_ready; bounded.
  task automatic wait_ready(input string name, input int exp_n);
    int  n = 0;
    bit  seen = 0;
    while (!seen && n < 30) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.key_ready) seen = 1;
    end
    check(name, 128'(n), 128'(exp_n));
  endtask

  task automatic set_round(input string name, input int r, input logic [127:0] exp);
    @(negedge clk);
    bus.round = 4'(r);
    #1;
    check(name, bus.round_key, exp);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  rk_arr_t fips_rk;
  rk_arr_t keyb_rk;

  initial begin
    for (int i = 0; i < 256; i++) sb_m[i] = sbox_calc(8'(i));
    fips_rk = expand_key(FIPS_KEY);
    keyb_rk = expand_key(KEY_B);

    // Pin the reference against literal FIPS-197 values.
    check("model_sbox_00", 128'(sb_m[8'h00]), 128'h63);
    check("model_sbox_53", 128'(sb_m[8'h53]), 128'hed);
    check("model_sbox_ff", 128'(sb_m[8'hff]), 128'h16);
    check("model_rk0", fips_rk[0], FIPS_KEY);
    check("model_rk1", fips_rk[1], FIPS_RK1);
    check("model_rk10", fips_rk[10], FIPS_RK10);

    n_rst        = 1'b0;
    bus.key_load = 1'b0;
    bus.key_in   = '0;
    bus.round    = '0;
`ifdef AES_KEY_ZEROIZE_EN
    bus.key_zeroize = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    // Reset state: all slots zero, including out-of-range indices.
    for (int r = 0; r < 16; r++) set_round("reset_round_key", r, 128'h0);
    check("reset_ready", 128'(bus.key_ready), 128'h0);
    check("reset_busy", 128'(bus.key_busy), 128'h0);
    check("reset_state", 128'(bus.state), 128'(IDLE));

    // FIPS-197 key: latency and spot values.
    load_key(FIPS_KEY);
    wait_ready("fips_latency", 10);
    set_round("fips_rk0", 0, FIPS_KEY);
    set_round("fips_rk1", 1, FIPS_RK1);
    set_round("fips_rk10", 10, FIPS_RK10);

    // Decrypt-order sweep and out-of-range indices.
    for (int r = 10; r >= 0; r--) set_round("dec_sweep", r, fips_rk[r]);
    for (int r = 11; r < 16; r++) set_round("oob_round", r, 128'h0);

    // Restart mid-expansion: zero key, then the FIPS key at cycle 5.
    load_key(128'h0);
    repeat (4) @(posedge clk);
    load_key(FIPS_KEY);
    wait_ready("restart_latency", 10);
    set_round("restart_rk10", 10, FIPS_RK10);
    for (int r = 0; r < 11; r++) set_round("restart_sweep", r, fips_rk[r]);

    // Reload from READY, then async reset at expansion cycle 3.
    load_key(KEY_B);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("midrst_state", 128'(bus.state), 128'(IDLE));
    check("midrst_busy", 128'(bus.key_busy), 128'h0);
    check("midrst_ready", 128'(bus.key_ready), 128'h0);
    for (int r = 0; r < 11; r++) set_round("midrst_slot", r, 128'h0);
    @(negedge clk);
    n_rst = 1'b1;

    // Load after reset expands correctly.
    load_key(KEY_B);
    wait_ready("postrst_latency", 10);
    for (int r = 10; r >= 0; r--) set_round("postrst_sweep", r, keyb_rk[r]);

`ifdef AES_KEY_ZEROIZE_EN
    // Zeroize wins over a simultaneous load.
    @(negedge clk);
    bus.key_in      = FIPS_KEY;
    bus.key_load    = 1'b1;
    bus.key_zeroize = 1'b1;
    @(negedge clk);
    bus.key_load    = 1'b0;
    bus.key_zeroize = 1'b0;
    #1;
    check("zero_state", 128'(bus.state), 128'(IDLE));
    check("zero_ready", 128'(bus.key_ready), 128'h0);
    check("zero_busy", 128'(bus.key_busy), 128'h0);
    for (int r = 0; r < 11; r++) set_round("zero_slot", r, 128'h0);
`endif

    repeat (2) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- AES-128 key schedule stage directly upstream of the AES round controller.
- Accepts a 128-bit cipher key, expands it iteratively into 11 round keys (one per cycle), and stores them in a register file.
- Serves round_key combinationally for whatever round index the controller drives, in both encrypt (0→10) and decrypt (10→0) order.
- Top level gates the controller's start with key_ready.

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds; fixed at 10 for AES-128, and other values are unsupported.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- key_load  input  1  single-cycle pulse; capture key_in and start expansion
- key_in  input  128  cipher key; bits [127:96] = w0, MSB = first key byte
- round  input  4  round-key index requested by the controller
- round_key  output  128  stored key for index round
- key_busy  output  1  expansion in progress
- key_ready  output  1  all 11 round keys valid

Behaviour:
- Reset: all 11 slots = 0, state IDLE, counter = 0, key_busy = 0, key_ready = 0. Reset is asynchronous at any time, including mid-expansion, and discards partial results.
- FSM states:
  - IDLE: no valid key.
  - EXPAND: counter 1..10.
  - READY.
- key_load in any state, sampled at a rising edge:
  - slot0 <= key_in, counter <= 1, state <= EXPAND.
  - key_ready <= 0, key_busy <= 1.
- EXPAND, each cycle:
  - slot[counter] <= f(slot[counter-1], rcon[counter]).
  - counter increments.
  - When counter == 10 the write happens, then state <= READY, key_busy <= 0, key_ready <= 1.
- Latency: key_load sampled at edge N gives key_ready high after edge N+10. Slot k is valid after edge N+k.
- key_load during EXPAND restarts from the new key. No old-key slots are mixed in, because every slot 1..10 is rewritten before key_ready.
- key_load in READY drops key_ready the next cycle and re-expands.
- Expansion function f, with prev words p0..p3, p0 in the high bits:
  - t = SubWord(RotWord(p3)) ^ {rcon,24'h0}.
  - RotWord is a left byte rotate: [b0 b1 b2 b3] → [b1 b2 b3 b0].
  - n0 = p0^t, n1 = p1^n0, n2 = p2^n1, n3 = p3^n2. Result = {n0,n1,n2,n3}.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- round_key = slot[round] combinationally, zero-latency read, to match the controller's same-cycle use.
- round > 10 → round_key = 0.
- Reads during EXPAND return current slot contents, stale or partial. Consumers must wait for key_ready.
- key_busy and key_ready are never high together.

Optional Feature:
- Macro: AES_KEY_ZEROIZE_EN.
- When defined:
  - Adds input key_zeroize (1 bit).
  - Asserted at an edge, it clears all slots to 0, returns to IDLE, and drops key_busy and key_ready.
  - key_zeroize has priority over a simultaneous key_load; the load is ignored.
- When undefined: no port and no logic. Key material persists until reset or a new load.

Decomposition:
- Shared package aes_pkg holds:
  - NUM_ROUND_KEYS = 11.
  - The rcon constant array.
  - typedef key_state_t {IDLE, EXPAND, READY}.
  - A 128-bit block type.
- Sub-module aes_sbox: combinational byte S-box, 8-bit in and 8-bit out, instantiated 4× for SubWord. The same module is reused by the round datapath.

Test Plan:
- Reset, then read → round_key = 0 for all rounds, key_ready = 0, key_busy = 0.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c pulsed → key_ready high exactly 10 cycles later; round=0 → 2b7e1516…; round=1 → a0fafe1788542cb123a339392a6c7605; round=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- Same key, then round swept 10→0 (decrypt order) → every slot matches the FIPS-197 Appendix A.1 values; round=11..15 → 0.
- key_load of key 000…0 at EXPAND cycle 5, then key 2b7e… → no key_ready before the restart completes; round=10 → d014f9a8… after 10 cycles from the second load.
- n_rst low at EXPAND cycle 3 → all slots 0, IDLE immediately; a subsequent load expands correctly.
- With AES_KEY_ZEROIZE_EN: in READY, key_zeroize and key_load pulsed together → key_ready = 0, all slots 0, state IDLE.
